// File: rtl/seg7_source_sched.sv
// seg7_source_sched
//   Shares one 8-digit seven-segment display between NSRC 32-bit CPU debug
//   sources. In SHOW it tracks the selected source and rotates through the
//   valid ones, either on a dwell timer (mode_auto=1) or on a step pulse.
//   A CPU MMIO write pre-empts rotation and shows the written value for
//   HOLD_CYCLES cycles (OVERRIDE), unless restarted by another write or
//   cancelled by a step pulse.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   src_data   NSRC packed 32-bit sources, source i at [32*i+31:32*i]
//   src_valid  per-source eligibility
//   mode_auto  1 = timed rotation, 0 = manual stepping only
//   next_pulse one-cycle step request (debounced upstream)
//   wr_en      one-cycle CPU write strobe
//   wr_data    value to display on a write
//   data_out   registered value for the display driver
//   cur_src    index of the selected source
//   ovr_active high while the written value is displayed
//   wr_ack     one-cycle acknowledge of wr_en
module seg7_source_sched #(
  parameter int NSRC         = 4,
  parameter int SEL_W        = 2,
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int CNT_W        = 27
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC*32-1:0]   src_data,
  input  logic [NSRC-1:0]      src_valid,
  input  logic                 mode_auto,
  input  logic                 next_pulse,
  input  logic                 wr_en,
  input  logic [31:0]          wr_data,
  output logic [31:0]          data_out,
  output logic [SEL_W-1:0]     cur_src,
  output logic                 ovr_active,
  output logic                 wr_ack
);

  typedef enum logic {
    SHOW     = 1'b0,
    OVERRIDE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

  state_t             state;
  logic [CNT_W-1:0]   dwell_cnt;
  logic [CNT_W-1:0]   hold_cnt;
  logic [31:0]        ovr_val;
  logic [NSRC-1:0][31:0] src_arr;
  logic               advance;

  assign src_arr = src_data;

  // Pulse and dwell expiry coinciding still give one advance.
  assign advance = next_pulse || (mode_auto && (dwell_cnt == DWELL_LAST));

  // First valid index after cur, searching cyclically and stopping before
  // cur itself; returns cur when no other source is valid.
  function automatic logic [SEL_W-1:0] next_src(input logic [SEL_W-1:0] cur,
                                                 input logic [NSRC-1:0]  vld);
    logic [SEL_W-1:0] res;
    logic [SEL_W:0]   sum;
    logic             found;
    res   = cur;
    found = 1'b0;
    for (int k = 1; k < NSRC; k++) begin
      sum = {1'b0, cur} + (SEL_W+1)'(k);
      if (sum >= (SEL_W+1)'(NSRC)) sum = sum - (SEL_W+1)'(NSRC);
      if (!found && vld[sum[SEL_W-1:0]]) begin
        res   = sum[SEL_W-1:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Single registered stage: state, counters and all outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SHOW;
      cur_src    <= '0;
      data_out   <= '0;
      dwell_cnt  <= '0;
      hold_cnt   <= '0;
      ovr_val    <= '0;
      ovr_active <= 1'b0;
      wr_ack     <= 1'b0;
    end else begin
      wr_ack <= wr_en;
      if (wr_en) begin
        // A write wins over step/expiry in the same cycle; the written
        // value is visible right after this edge.
        ovr_val    <= wr_data;
        hold_cnt   <= '0;
        state      <= OVERRIDE;
        ovr_active <= 1'b1;
        data_out   <= wr_data;
      end else if (state == SHOW) begin
        if (src_valid[cur_src]) data_out <= src_arr[cur_src];
        if (advance) begin
          cur_src   <= next_src(cur_src, src_valid);
          dwell_cnt <= '0;
        end else if (mode_auto) begin
          dwell_cnt <= dwell_cnt + 1'b1;
        end else begin
          dwell_cnt <= '0;
        end
      end else begin
        if (next_pulse || (hold_cnt == HOLD_LAST)) begin
          // Leaving override: the first SHOW cycle reloads from cur_src
          // and the dwell period starts fresh.
          state      <= SHOW;
          ovr_active <= 1'b0;
          dwell_cnt  <= '0;
          if (src_valid[cur_src]) data_out <= src_arr[cur_src];
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
          data_out <= ovr_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_source_sched.sv
module tb_seg7_source_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] src_data;
  logic [3:0]   src_valid;
  logic         mode_auto;
  logic         next_pulse;
  logic         wr_en;
  logic [31:0]  wr_data;
  logic [31:0]  data_out;
  logic [1:0]   cur_src;
  logic         ovr_active;
  logic         wr_ack;

  int checks = 0;
  int errors = 0;

  logic [31:0] srcv [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  seg7_source_sched #(
    .NSRC(4), .SEL_W(2), .DWELL_CYCLES(8), .HOLD_CYCLES(5), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_valid(src_valid),
    .mode_auto(mode_auto), .next_pulse(next_pulse), .wr_en(wr_en),
    .wr_data(wr_data), .data_out(data_out), .cur_src(cur_src),
    .ovr_active(ovr_active), .wr_ack(wr_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    src_data   = {srcv[3], srcv[2], srcv[1], srcv[0]};
    src_valid  = 4'b1111;
    mode_auto  = 1'b1;
    next_pulse = 1'b0;
    wr_en      = 1'b0;
    wr_data    = '0;

    // Reset held for two edges
    tick();
    tick();
    check("rst_data", data_out, 32'h0);
    check("rst_cur", 32'(cur_src), 32'd0);
    check("rst_ovr", 32'(ovr_active), 32'd0);
    check("rst_ack", 32'(wr_ack), 32'd0);
    rst_n = 1'b1;

    // Auto rotation every 8 cycles; pulse on the expiry cycle at n=40
    for (int n = 1; n <= 48; n++) begin
      if (n == 40) next_pulse = 1'b1;
      tick();
      next_pulse = 1'b0;
      if (n == 1) check("auto_first_data", data_out, srcv[0]);
      if (n == 7) check("auto_before_step", 32'(cur_src), 32'd0);
      if (n == 8 || n == 16 || n == 24 || n == 32)
        check("auto_cur", 32'(cur_src), 32'((n / 8) % 4));
      if (n == 9 || n == 17 || n == 25 || n == 33)
        check("auto_data", data_out, srcv[((n - 1) / 8) % 4]);
      if (n == 40) check("pulse_on_expiry_cur", 32'(cur_src), 32'd1);
      if (n == 47) check("dwell_restart_hold", 32'(cur_src), 32'd1);
      if (n == 48) check("dwell_restart_step", 32'(cur_src), 32'd2);
    end

    // Manual stepping with skip and wrap (valid 1001)
    mode_auto  = 1'b0;
    src_valid  = 4'b1001;
    next_pulse = 1'b1; tick(); next_pulse = 1'b0;
    check("skip_to_3", 32'(cur_src), 32'd3);
    tick();
    check("skip_data3", data_out, srcv[3]);
    next_pulse = 1'b1; tick(); next_pulse = 1'b0;
    check("wrap_to_0", 32'(cur_src), 32'd0);
    src_valid  = 4'b0001;
    next_pulse = 1'b1; tick(); next_pulse = 1'b0;
    check("single_valid_stay", 32'(cur_src), 32'd0);
    tick();
    check("single_valid_data", data_out, srcv[0]);
    tick();
    check("manual_no_auto_step", 32'(cur_src), 32'd0);

    // Basic override, 5-cycle hold
    src_valid = 4'b1111;
    wr_en = 1'b1; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0;
    check("ovr_data", data_out, 32'hDEADBEEF);
    check("ovr_active1", 32'(ovr_active), 32'd1);
    check("ovr_ack1", 32'(wr_ack), 32'd1);
    tick();
    check("ovr_ack_drop", 32'(wr_ack), 32'd0);
    check("ovr_data2", data_out, 32'hDEADBEEF);
    tick(); tick(); tick();
    check("ovr_active5", 32'(ovr_active), 32'd1);
    tick();
    check("ovr_end", 32'(ovr_active), 32'd0);
    check("ovr_end_data", data_out, srcv[0]);
    check("ovr_end_cur", 32'(cur_src), 32'd0);

    // Write together with step: override entered, no advance
    wr_en = 1'b1; next_pulse = 1'b1; wr_data = 32'hCAFEF00D;
    tick();
    wr_en = 1'b0; next_pulse = 1'b0;
    check("wr_pulse_ovr", 32'(ovr_active), 32'd1);
    check("wr_pulse_cur", 32'(cur_src), 32'd0);
    check("wr_pulse_data", data_out, 32'hCAFEF00D);

    // Second write three cycles in restarts the hold
    tick(); tick();
    wr_en = 1'b1; wr_data = 32'h12345678;
    tick();
    wr_en = 1'b0;
    check("rewrite_data", data_out, 32'h12345678);
    check("rewrite_ack", 32'(wr_ack), 32'd1);
    tick(); tick(); tick(); tick();
    check("rewrite_still_ovr", 32'(ovr_active), 32'd1);
    tick();
    check("rewrite_end", 32'(ovr_active), 32'd0);
    check("rewrite_end_data", data_out, srcv[0]);

    // Cancel by step pulse keeps cur_src
    next_pulse = 1'b1; tick(); next_pulse = 1'b0;
    check("pre_cancel_cur", 32'(cur_src), 32'd1);
    wr_en = 1'b1; wr_data = 32'hA5A5A5A5;
    tick();
    wr_en = 1'b0;
    check("cancel_ovr_on", 32'(ovr_active), 32'd1);
    next_pulse = 1'b1; tick(); next_pulse = 1'b0;
    check("cancel_ovr_off", 32'(ovr_active), 32'd0);
    check("cancel_cur", 32'(cur_src), 32'd1);
    check("cancel_data", data_out, srcv[1]);

    // Reset in the middle of an override
    wr_en = 1'b1; wr_data = 32'h55AA55AA;
    tick();
    wr_en = 1'b0;
    check("pre_rst_ovr", 32'(ovr_active), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_data", data_out, 32'h0);
    check("mid_rst_cur", 32'(cur_src), 32'd0);
    check("mid_rst_ovr", 32'(ovr_active), 32'd0);
    check("mid_rst_ack", 32'(wr_ack), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_data", data_out, srcv[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
